// File: rtl/pixel_word_packer.sv
// Packs LANES samples of IN_W bits into one word with valid/ready on both sides,
// selectable lane order, flush-on-last padding and synchronous clear.
// Optional output-transfer counter word_cnt is built when PACKER_STATS_EN is defined.
module pixel_word_packer #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned LANES     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PAD_VAL   = 1'b1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IN_W*LANES-1:0]       out_data,
  output logic [$clog2(LANES+1)-1:0]  out_count,
  output logic                        out_last
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]                 word_cnt
`endif
);

  localparam int unsigned W  = IN_W * LANES;
  localparam int unsigned CW = $clog2(LANES + 1);
  localparam logic [W-1:0] PAD_WORD = {W{PAD_VAL}};

  typedef enum logic {ACC, OUT} state_t;

  state_t         state, state_next;
  logic [W-1:0]   acc, acc_next;
  logic [W-1:0]   data_q, data_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [CW-1:0]  count_q, count_next;
  logic           last_q, last_next;
  logic           in_xfer, out_xfer, complete;
  logic [CW-1:0]  lane;
  logic [W-1:0]   merged;

  assign out_valid = (state == OUT);
  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_last  = last_q;

  assign in_ready = !clear && (!out_valid || out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign complete = in_xfer && ((cnt == CW'(LANES - 1)) || in_last);
  assign lane     = MSB_FIRST ? (CW'(LANES - 1) - cnt) : cnt;

  // Accumulator with the incoming sample dropped into its lane.
  always_comb begin
    merged = acc;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (CW'(l) == lane) merged[l*IN_W +: IN_W] = in_data;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    data_next  = data_q;
    count_next = count_q;
    last_next  = last_q;
    if (clear) begin
      state_next = ACC;
      acc_next   = PAD_WORD;
      cnt_next   = '0;
      count_next = '0;
      last_next  = 1'b0;
    end else if (complete) begin
      // Also covers OUT with a concurrent output transfer: new word replaces old, no bubble.
      state_next = OUT;
      data_next  = merged;
      count_next = cnt + CW'(1);
      last_next  = in_last;
      acc_next   = PAD_WORD;
      cnt_next   = '0;
    end else begin
      if (in_xfer) begin
        acc_next = merged;
        cnt_next = cnt + CW'(1);
      end
      if (out_xfer) state_next = ACC;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= ACC;
      acc     <= PAD_WORD;
      cnt     <= '0;
      data_q  <= PAD_WORD;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_next;
      acc     <= acc_next;
      cnt     <= cnt_next;
      data_q  <= data_next;
      count_q <= count_next;
      last_q  <= last_next;
    end
  end

`ifdef PACKER_STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)        word_cnt <= '0;
    else if (clear)    word_cnt <= '0;
    else if (out_xfer) word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_word_packer.sv
// Scoreboard bench for pixel_word_packer: directed samples push expected words,
// per-DUT monitors pop and compare on every output transfer.
module tb_pixel_word_packer;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;

  logic        clear = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_valid, out_last;
  logic [31:0] out_data;
  logic [2:0]  out_count;

  logic        b_clear = 1'b0, b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
  logic [7:0]  b_in_data = '0;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [31:0] b_out_data;
  logic [2:0]  b_out_count;

`ifdef PACKER_STATS_EN
  logic [15:0] word_cnt, b_word_cnt;
`endif

  exp_t qa[$];
  exp_t qb[$];

  pixel_word_packer #(.IN_W(8), .LANES(4), .MSB_FIRST(1'b1), .PAD_VAL(1'b1)) dut_a (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last)
`ifdef PACKER_STATS_EN
    , .word_cnt(word_cnt)
`endif
  );

  pixel_word_packer #(.IN_W(8), .LANES(4), .MSB_FIRST(1'b0), .PAD_VAL(1'b1)) dut_b (
    .clk(clk), .n_rst(n_rst), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_count(b_out_count), .out_last(b_out_last)
`ifdef PACKER_STATS_EN
    , .word_cnt(b_word_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (n_rst && out_valid && out_ready) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL a_unexpected_word: got 0x%08h expected none", out_data);
      end else begin
        e = qa.pop_front();
        check("a_out_data", out_data, e.data);
        check("a_out_count", out_count, e.count);
        check("a_out_last", out_last, e.last);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (n_rst && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL b_unexpected_word: got 0x%08h expected none", b_out_data);
      end else begin
        e = qb.pop_front();
        check("b_out_data", b_out_data, e.data);
        check("b_out_count", b_out_count, e.count);
        check("b_out_last", b_out_last, e.last);
      end
    end
  end

  // Presents one sample, waits (bounded) for acceptance, returns just after the accepting edge.
  task automatic send(input bit sel, input logic [7:0] d, input bit l);
    int unsigned t = 0;
    bit rdy;
    if (sel) begin b_in_valid = 1'b1; b_in_data = d; b_in_last = l; end
    else     begin in_valid = 1'b1;   in_data = d;   in_last = l;   end
    @(negedge clk);
    rdy = sel ? b_in_ready : in_ready;
    while (!rdy && t < 100) begin
      @(negedge clk);
      rdy = sel ? b_in_ready : in_ready;
      t++;
    end
    if (!rdy) begin
      total++;
      $display("FAIL send_timeout: sample 0x%02h not accepted within 100 cycles", d);
    end
    @(posedge clk); #1;
    if (sel) begin b_in_valid = 1'b0; b_in_last = 1'b0; end
    else     begin in_valid = 1'b0;   in_last = 1'b0;   end
  endtask

  task automatic push_a(input logic [31:0] d, input logic [2:0] c, input bit l);
    exp_t e;
    e.data = d; e.count = c; e.last = l;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] d, input logic [2:0] c, input bit l);
    exp_t e;
    e.data = d; e.count = c; e.last = l;
    qb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int start;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 32'hFFFF_FFFF);
    check("rst_out_count", out_count, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Back-to-back full word, MSB-first
    out_ready = 1'b1;
    push_a(32'h1122_3344, 3'd4, 1'b0);
    send(0, 8'h11, 0); send(0, 8'h22, 0); send(0, 8'h33, 0);
    check("t1_not_valid_early", out_valid, 0);
    send(0, 8'h44, 0);
    check("t1_latency_valid", out_valid, 1);

    // Short burst closed by in_last
    push_a(32'hAABB_FFFF, 3'd2, 1'b1);
    send(0, 8'hAA, 0); send(0, 8'hBB, 1);
    @(posedge clk); #1;

    // Stall with word pending, then stream without bubbles
    out_ready = 1'b0;
    push_a(32'h0102_0304, 3'd4, 1'b0);
    send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_in_ready", in_ready, 0);
      check("t3_stall_data", out_data, 32'h0102_0304);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    push_a(32'h0506_0708, 3'd4, 1'b0);
    push_a(32'h090A_0B0C, 3'd4, 1'b0);
    start = cyc;
    for (int i = 5; i <= 12; i++) send(0, 8'(i), 0);
    check("t3_stream_cycles", cyc - start, 8);
    repeat (2) @(posedge clk); #1;

    // LSB-first instance
    push_b(32'h4433_2211, 3'd4, 1'b0);
    push_b(32'hFFFF_FF55, 3'd1, 1'b1);
    send(1, 8'h11, 0); send(1, 8'h22, 0); send(1, 8'h33, 0); send(1, 8'h44, 0);
    send(1, 8'h55, 1);
    repeat (2) @(posedge clk); #1;

    // Reset mid-word
    send(0, 8'h21, 0); send(0, 8'h22, 0);
    n_rst = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 32'hFFFF_FFFF);
    check("t5_out_count", out_count, 0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    push_a(32'h0102_0304, 3'd4, 1'b0);
    send(0, 8'h01, 0); send(0, 8'h02, 0); send(0, 8'h03, 0); send(0, 8'h04, 0);
    repeat (2) @(posedge clk); #1;

    // Clear with word pending, then clear with three lanes filled
    out_ready = 1'b0;
    send(0, 8'hC1, 0); send(0, 8'hC2, 0); send(0, 8'hC3, 0); send(0, 8'hC4, 0);
    clear = 1'b1;
    @(negedge clk);
    check("t6_clear_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0;
    check("t6_clear_out_valid", out_valid, 0);
    check("t6_clear_out_count", out_count, 0);
    check("t6_clear_out_last", out_last, 0);
`ifdef PACKER_STATS_EN
    check("t6_word_cnt_cleared", word_cnt, 0);
`endif
    send(0, 8'hD1, 0); send(0, 8'hD2, 0); send(0, 8'hD3, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    out_ready = 1'b1;
    push_a(32'hE1FF_FFFF, 3'd1, 1'b1);
    send(0, 8'hE1, 1);
    repeat (3) @(posedge clk); #1;
`ifdef PACKER_STATS_EN
    check("t6_word_cnt_one", word_cnt, 1);
`endif

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
